// File: rtl/scrambler_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_frame_ctrl
// Purpose  : Frame sequencer in front of a bit-serial scrambler. On start it
//            clears the scrambler LFSR, sends a fixed preamble so the far-end
//            self-synchronising descrambler can lock, then streams a
//            programmable number of payload bits from a valid/ready source.
// Ports    : clk_i, rst_i        clock (rising edge), synchronous reset (high)
//            start_i, abort_i    frame start (IDLE only) / frame abandon
//            len_i               payload length in bits, latched on start
//            bit_i, bit_valid_i  payload source bit and its valid
//            bit_ready_o         payload bit accepted this cycle (with valid)
//            scr_clr_o           scrambler LFSR clear pulse
//            scr_en_o, scr_bit_o scrambler advance enable and input bit
//            sof_o, eof_o        first preamble bit / last bit of frame
//            busy_o, done_o      not idle / one-cycle normal-completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module scrambler_frame_ctrl #(
  parameter int                 PRE_LEN     = 16,
  parameter logic [PRE_LEN-1:0] PRE_PATTERN = 16'hA5F0,
  parameter int                 LEN_W       = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic             bit_ready_o,
  output logic             scr_clr_o,
  output logic             scr_en_o,
  output logic             scr_bit_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PRE_CNT_W = $clog2(PRE_LEN);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_CLEAR = 3'd1;
  localparam logic [2:0] c_ST_PRE   = 3'd2;
  localparam logic [2:0] c_ST_PAY   = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  localparam logic [PRE_CNT_W-1:0] c_PRE_LAST = PRE_CNT_W'(PRE_LEN - 1);

  logic [2:0]           state_q,   state_d;
  logic [PRE_CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0]     pay_cnt_q, pay_cnt_d;
  logic [LEN_W-1:0]     len_q,     len_d;
  // Preamble is shifted out MSB first; loading it in CLEAR avoids a
  // variable-index mux on the pattern constant.
  logic [PRE_LEN-1:0]   pre_sh_q,  pre_sh_d;

  logic w_pre_last;
  logic w_len_zero;
  logic w_pay_last;
  logic w_xfer;

  assign w_pre_last = (pre_cnt_q == c_PRE_LAST);
  assign w_len_zero = (len_q == '0);
  // Compared in LEN_W bits so an all-ones length ends on count 2**LEN_W-2
  // without the counter ever wrapping.
  assign w_pay_last = (pay_cnt_q == (len_q - LEN_W'(1)));
  assign w_xfer     = (state_q == c_ST_PAY) & bit_valid_i & ~abort_i;

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= c_ST_IDLE;
      pre_cnt_q <= '0;
      pay_cnt_q <= '0;
      len_q     <= '0;
      pre_sh_q  <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      len_q     <= len_d;
      pre_sh_q  <= pre_sh_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    pay_cnt_d = pay_cnt_q;
    len_d     = len_q;
    pre_sh_d  = pre_sh_q;

    case (state_q)
      c_ST_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          state_d = c_ST_CLEAR;
        end
      end
      c_ST_CLEAR: begin
        pre_cnt_d = '0;
        pre_sh_d  = PRE_PATTERN;
        state_d   = c_ST_PRE;
      end
      c_ST_PRE: begin
        pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
        pre_sh_d  = {pre_sh_q[PRE_LEN-2:0], 1'b0};
        if (w_pre_last) begin
          pay_cnt_d = '0;
          state_d   = w_len_zero ? c_ST_DONE : c_ST_PAY;
        end
      end
      c_ST_PAY: begin
        if (w_xfer) begin
          pay_cnt_d = pay_cnt_q + LEN_W'(1);
          if (w_pay_last) begin
            state_d = c_ST_DONE;
          end
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase

    // Abort overrides every transition out of a busy state.
    if (abort_i && (state_q != c_ST_IDLE)) begin
      state_d = c_ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (no combinational path from start_i)
  // --------------------------------------------------------------------------
  always_comb begin
    bit_ready_o = 1'b0;
    scr_clr_o   = 1'b0;
    scr_en_o    = 1'b0;
    scr_bit_o   = 1'b0;
    sof_o       = 1'b0;
    eof_o       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      c_ST_CLEAR: begin
        busy_o    = 1'b1;
        scr_clr_o = 1'b1;
      end
      c_ST_PRE: begin
        busy_o    = 1'b1;
        scr_en_o  = ~abort_i;
        scr_bit_o = pre_sh_q[PRE_LEN-1];
        sof_o     = ~abort_i & (pre_cnt_q == '0);
        eof_o     = ~abort_i & w_pre_last & w_len_zero;
      end
      c_ST_PAY: begin
        busy_o      = 1'b1;
        bit_ready_o = ~abort_i;
        scr_en_o    = w_xfer;
        scr_bit_o   = bit_i;
        eof_o       = w_xfer & w_pay_last;
      end
      c_ST_DONE: begin
        busy_o = 1'b1;
        done_o = ~abort_i;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
